dsi_cmd_line_framer: RTL
========================

Name: dsi_cmd_line_framer

Overview:
- Parametrised successor to the command-mode TX packetiser. Buffers packed pixel words from the scaler in an internal FIFO and emits one DSI DCS long-write packet (0x39) per display line to the host TX controller.
- A line is launched only when the whole line is already buffered. The block counts lines per frame, checks the DCS header byte and line length, and flags frame overruns.
- Sits between the scaler output and the MIPI host TX, in the single scaler clock domain.

Parameters:
TX_X_RESOLUTION, 1080, pixels per line; packet byte count = TX_X_RESOLUTION*3+1
TX_Y_RESOLUTION, 2160, lines per frame
WORDS_PER_LINE, (TX_X_RESOLUTION*3+4)/4, 32-bit words per line packet (derived, integer division)
FIFO_AW, 11, FIFO address width; depth = 2**FIFO_AW, must be >= WORDS_PER_LINE
VC, 2'b00, DSI virtual channel

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
in_data  in  32  packed line word; byte0 of a line's first word is the DCS command
in_valid  in  1  in_data valid
in_ready  out  1  !fifo_full; push occurs when in_valid&&in_ready
in_vs  in  1  one-cycle frame-start pulse from scaler
host_tx_cmd_req  out  1  packet request
host_tx_cmd_ack  in  1  host accepts header
host_tx_payload_en  in  1  host consumes host_tx_payload this cycle
host_tx_payload_en_last  in  1  last payload word of packet
host_tx_cmd_vc  out  2  = VC
host_tx_cmd_data_type  out  6  constant 6'h39
host_tx_cmd_byte_count  out  16  constant TX_X_RESOLUTION*3+1
host_tx_hs_mode  out  1  constant 1
host_tx_payload  out  32  FIFO head (show-ahead, registered)
frame_busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last line of frame
line_cnt  out  12  lines completed in current frame
fifo_level  out  FIFO_AW+1  words stored
err_clr  in  1  clears sticky errors
hdr_err, len_err, ovr_err  out  1 each  sticky error flags

Behaviour:
- Reset: all outputs 0 except host_tx_hs_mode=1, constants and in_ready=1; FSM=IDLE; FIFO emptied. Reset mid-packet aborts immediately; the host must also be reset.
- FIFO: push/pop same cycle leaves level unchanged. Pop occurs when host_tx_payload_en in PAYLOAD and level>0. Push when full is impossible (in_ready=0). Pop when empty is ignored and sets len_err. Head valid one cycle after first push.
- FSM states: IDLE, WAIT_LINE, REQ, PAYLOAD, LINE_DONE.
  - IDLE: in_vs -> WAIT_LINE; line_cnt<=0; frame_busy<=1.
  - WAIT_LINE: fifo_level>=WORDS_PER_LINE -> REQ.
  - REQ: host_tx_cmd_req=1 until the cycle host_tx_cmd_ack=1 -> PAYLOAD, req<=0 next cycle.
  - PAYLOAD: count pops. On the first pop, check head[7:0]: expected 8'h2C if line_cnt==0, else 8'h3C; a mismatch sets hdr_err (data still sent). On host_tx_payload_en_last (with its pop) -> LINE_DONE; if popped count != WORDS_PER_LINE, set len_err.
  - LINE_DONE (1 cycle): line_cnt+1. If the new value == TX_Y_RESOLUTION -> frame_done pulse, frame_busy<=0, IDLE; else -> WAIT_LINE.
- in_vs while frame_busy: set ovr_err; the current packet completes; at the next LINE_DONE, line_cnt<=0 and -> WAIT_LINE (new frame). No FIFO flush.
- in_vs coinciding with the frame_done cycle: treated as a new frame start, not an overrun.
- err_clr has priority below a same-cycle error set (error wins).
- line_cnt is 12 bits; TX_Y_RESOLUTION must be <4096.

Optional Feature:
DSI_TE_SYNC_EN:
- Defined: adds input te (1 bit, already synchronous to clk). After in_vs in IDLE, FSM enters WAIT_TE and waits for a te rising edge (te=1 with previous te=0) before WAIT_LINE. Input words are still buffered during the wait.
- Undefined: no te port; IDLE goes directly to WAIT_LINE.

Test Plan:
- X=4 (13 bytes, WORDS_PER_LINE=4), Y=3; in_vs then 12 words with line-first bytes 2C,3C,3C; host acks after 2 cycles -> exactly 3 req/ack, 4 pops each, line_cnt 1,2,3, frame_done one cycle after the third LINE_DONE, no errors.
- Same config, only 3 words pushed -> req stays 0. Push the 4th word -> req rises 2 cycles later (level update + WAIT_LINE->REQ).
- Fill to full with host stalled -> in_ready=0 at fifo_level=2**FIFO_AW, no data loss. Release -> in_ready returns 1 the cycle after the first pop.
- Second line's first byte 2C instead of 3C -> hdr_err=1 and held. err_clr -> 0 next cycle.
- Host asserts payload_en_last after 3 words -> len_err=1. in_vs mid-line-2 -> ovr_err=1, line_cnt=0 after that LINE_DONE.
- DSI_TE_SYNC_EN defined: in_vs with a full line buffered, te rises 50 cycles later -> req not before te edge, req rises 2 cycles after it.

Source files
------------

// File: rtl/dsi_cmd_line_framer.sv
// dsi_cmd_line_framer: buffers packed scaler words in a show-ahead FIFO and
// emits one DCS long-write (0x39) packet per display line to the host TX.
// A line is requested only once the whole line is buffered. Lines per frame
// are counted, the DCS header byte and line length are checked, and frame
// overruns are flagged with sticky error bits.
// Optional build macro: DSI_TE_SYNC_EN adds the te input and a WAIT_TE state
// that holds the frame start until a te rising edge.
module dsi_cmd_line_framer #(
  parameter int         TX_X_RESOLUTION = 1080,
  parameter int         TX_Y_RESOLUTION = 2160,
  parameter int         WORDS_PER_LINE  = (TX_X_RESOLUTION * 3 + 4) / 4,
  parameter int         FIFO_AW         = 11,
  parameter logic [1:0] VC              = 2'b00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_vs,
`ifdef DSI_TE_SYNC_EN
  input  logic               te,
`endif
  output logic               host_tx_cmd_req,
  input  logic               host_tx_cmd_ack,
  input  logic               host_tx_payload_en,
  input  logic               host_tx_payload_en_last,
  output logic [1:0]         host_tx_cmd_vc,
  output logic [5:0]         host_tx_cmd_data_type,
  output logic [15:0]        host_tx_cmd_byte_count,
  output logic               host_tx_hs_mode,
  output logic [31:0]        host_tx_payload,
  output logic               frame_busy,
  output logic               frame_done,
  output logic [11:0]        line_cnt,
  output logic [FIFO_AW:0]   fifo_level,
  input  logic               err_clr,
  output logic               hdr_err,
  output logic               len_err,
  output logic               ovr_err
);

  localparam int                 DEPTH      = 2 ** FIFO_AW;
  localparam int                 BYTE_CNT_I = TX_X_RESOLUTION * 3 + 1;
  localparam int                 WPL_I      = WORDS_PER_LINE;
  localparam int                 Y_I        = TX_Y_RESOLUTION;
  localparam logic [FIFO_AW:0]   WPL_W      = WPL_I[FIFO_AW:0];
  localparam logic [15:0]        WPL16      = WPL_I[15:0];
  localparam logic [11:0]        Y_W        = Y_I[11:0];
  localparam logic [FIFO_AW:0]   FULL_W     = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   LVL_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   LVL_ZERO   = {(FIFO_AW+1){1'b0}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINE = 3'd1,
    REQ       = 3'd2,
    PAYLOAD   = 3'd3,
    LINE_DONE = 3'd4
`ifdef DSI_TE_SYNC_EN
    ,WAIT_TE  = 3'd5
`endif
  } state_t;

  // FIFO storage and pointers
  logic [31:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               in_ready_q;
  logic [31:0]        head_q, head_d;

  // Control state
  state_t             state_q;
  logic               req_q;
  logic               frame_busy_q;
  logic               frame_done_q;
  logic [11:0]        line_cnt_q;
  logic [15:0]        pop_cnt_q;
  logic               restart_q;
  logic               hdr_err_q, len_err_q, ovr_err_q;
`ifdef DSI_TE_SYNC_EN
  logic               te_q;
`endif

  // Per-cycle events
  logic               push, pop, pop_empty;
  logic               hdr_set, len_set, ovr_set;
  logic [7:0]         exp_hdr;

  // Handshake decode and error-set detection for this cycle
  always_comb begin
    push      = in_valid && in_ready_q;
    pop       = (state_q == PAYLOAD) && host_tx_payload_en && (level_q != LVL_ZERO);
    pop_empty = (state_q == PAYLOAD) && host_tx_payload_en && (level_q == LVL_ZERO);
    exp_hdr   = (line_cnt_q == 12'd0) ? 8'h2C : 8'h3C;
    hdr_set   = pop && (pop_cnt_q == 16'd0) && (head_q[7:0] != exp_hdr);
    len_set   = pop_empty ||
                ((state_q == PAYLOAD) && host_tx_payload_en_last &&
                 ((pop_cnt_q + {15'd0, pop}) != WPL16));
    ovr_set   = in_vs && frame_busy_q;
  end

  // FIFO next-state: pointers, level and bypassed show-ahead head word
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = in_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage write port (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointer, level, ready and head registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {FIFO_AW{1'b0}};
      rd_ptr_q   <= {FIFO_AW{1'b0}};
      level_q    <= LVL_ZERO;
      in_ready_q <= 1'b1;
      head_q     <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= (level_d != FULL_W);
      head_q     <= head_d;
    end
  end

  // Line/frame sequencer with registered request and frame status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      line_cnt_q   <= 12'd0;
      pop_cnt_q    <= 16'd0;
      restart_q    <= 1'b0;
`ifdef DSI_TE_SYNC_EN
      te_q         <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
`ifdef DSI_TE_SYNC_EN
      te_q         <= te;
`endif
      // A frame start arriving mid-frame restarts the count at the next line end
      if (ovr_set) begin
        restart_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (in_vs) begin
`ifdef DSI_TE_SYNC_EN
            state_q <= WAIT_TE;
`else
            state_q <= WAIT_LINE;
`endif
            line_cnt_q   <= 12'd0;
            frame_busy_q <= 1'b1;
          end
        end
`ifdef DSI_TE_SYNC_EN
        WAIT_TE: begin
          if (te && !te_q) begin
            state_q <= WAIT_LINE;
          end
        end
`endif
        WAIT_LINE: begin
          if (level_q >= WPL_W) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (host_tx_cmd_ack) begin
            state_q   <= PAYLOAD;
            req_q     <= 1'b0;
            pop_cnt_q <= 16'd0;
          end
        end
        PAYLOAD: begin
          if (pop) begin
            pop_cnt_q <= pop_cnt_q + 16'd1;
          end
          if (host_tx_payload_en_last) begin
            state_q <= LINE_DONE;
          end
        end
        LINE_DONE: begin
          restart_q <= 1'b0;
          if (restart_q || in_vs) begin
            line_cnt_q <= 12'd0;
            state_q    <= WAIT_LINE;
          end else if ((line_cnt_q + 12'd1) == Y_W) begin
            line_cnt_q   <= line_cnt_q + 12'd1;
            frame_done_q <= 1'b1;
            frame_busy_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            line_cnt_q <= line_cnt_q + 12'd1;
            state_q    <= WAIT_LINE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a same-cycle set overrides err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_err_q <= 1'b0;
      len_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      hdr_err_q <= (hdr_err_q && !err_clr) || hdr_set;
      len_err_q <= (len_err_q && !err_clr) || len_set;
      ovr_err_q <= (ovr_err_q && !err_clr) || ovr_set;
    end
  end

  assign in_ready               = in_ready_q;
  assign host_tx_cmd_req        = req_q;
  assign host_tx_cmd_vc         = VC;
  assign host_tx_cmd_data_type  = 6'h39;
  assign host_tx_cmd_byte_count = BYTE_CNT_I[15:0];
  assign host_tx_hs_mode        = 1'b1;
  assign host_tx_payload        = head_q;
  assign frame_busy             = frame_busy_q;
  assign frame_done             = frame_done_q;
  assign line_cnt               = line_cnt_q;
  assign fifo_level             = level_q;
  assign hdr_err                = hdr_err_q;
  assign len_err                = len_err_q;
  assign ovr_err                = ovr_err_q;

endmodule
